// File: rtl/dual_edge_mix_pipe.sv
// Dual-edge XOR fold: a rising-edge register p and a falling-edge register n each mix d with
// the other's state. A mode-selected result feeds a stallable, valid-tracked output pipeline.
module dual_edge_mix_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [1:0] MODE_P    = 2'b00;
  localparam logic [1:0] MODE_N    = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] n;
  logic             p_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] stg_valid;

  assign in_ready = en;
  assign accept   = in_valid && en;

  // n lives on the falling edge, so p -> n and n -> p are both half-cycle paths.
  always_ff @(negedge clk) begin
    if (rst) begin
      n <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      n <= d ^ p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p       <= '0;
      p_valid <= 1'b0;
    end else if (en) begin
      if (in_valid) begin
        p <= d ^ n;
      end
      p_valid <= in_valid;
    end
  end

  always_comb begin
    // NOTE: a default before the case guarantees every path assigns sel_data, so no latch is inferred.
    sel_data = stg_data[0];
    case (mode)
      MODE_P:    sel_data = p;
      MODE_N:    sel_data = n;
      MODE_XOR:  sel_data = p ^ n;
      MODE_HOLD: sel_data = stg_data[0];
      default:   sel_data = stg_data[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pipeline is a handful of flops whose data is visible on q, so it is reset
      // alongside its valids; a RAM-style array would normally be left unreset.
      for (int k = 0; k < DEPTH; k++) begin
        stg_data[k] <= '0;
      end
      stg_valid <= '0;
    end else if (en) begin
      stg_data[0]  <= sel_data;
      stg_valid[0] <= p_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stg_data[k]  <= stg_data[k-1];
        stg_valid[k] <= stg_valid[k-1];
      end
    end
  end

  assign q         = stg_data[DEPTH-1];
  assign out_valid = stg_valid[DEPTH-1];

  // Saturating count of output beats taken while the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (en && out_valid && (out_cnt != {CNT_W{1'b1}})) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule
